alu_op_sequencer: RTL

//  Issue controller for the 24-bit ALU result mux. Accepts one op per valid/ready handshake and

---
 rtl/alu_op_sequencer_pkg.sv | 37 +++
 rtl/alu_op_sequencer_mul_iter.sv | 72 +++++++
 rtl/alu_op_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_pkg
// Shared definitions for the ALU issue sequencer and the decode stage: default
// datapath width, selector width, opcode encodings, FSM state encodings and an
// opcode classification helper.
// Optional feature macro: ALU_MUL_EN (MUL opcode becomes legal when defined).
// -----------------------------------------------------------------------------
package alu_op_sequencer_pkg;

  localparam int ALU_WIDTH = 24;
  localparam int ALU_SEL_W = 3;

  // Opcode / result-mux selector encodings
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 3'b000;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 3'b001;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [ALU_SEL_W-1:0] ALU_LESS = 3'b011;
  localparam logic [ALU_SEL_W-1:0] ALU_MUL  = 3'b100;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 3'b101;

  // Sequencer FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MULT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // True for opcodes that complete through the ALU result mux in one cycle.
  function automatic logic is_single_cycle_op(input logic [ALU_SEL_W-1:0] op);
    logic r;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_LESS, ALU_XOR: r = 1'b1;
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_mul_iter
// Iterative shift-add multiplier, one partial-product bit per cycle, returning
// the low WIDTH bits of the unsigned product. Only instantiated when
// ALU_MUL_EN is defined.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_start         load operands (one-cycle strobe)
//   i_a, i_b        multiplicand / multiplier
//   o_done          high in the cycle whose closing edge finishes the product
//   o_product       product value valid to capture while o_done is high
// -----------------------------------------------------------------------------
module alu_op_sequencer_mul_iter #(
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_acc_next;

  // Partial product for the current multiplier bit folded into the accumulator.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});

  // The last iteration's sum is exposed directly so the caller captures the
  // finished product on the same edge the iteration completes.
  assign o_done    = r_run && (r_cnt == LAST_CNT);
  assign o_product = w_acc_next;

  // Iteration state: load on start, then shift one bit per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= {CNT_W{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == LAST_CNT) begin
        r_run <= 1'b0;
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Issue controller for the 24-bit ALU result mux. Accepts one op per
// OpValid/OpReady handshake, registers operands and selector onto the ALU,
// captures the mux output and returns it with a ResValid/ResReady handshake.
// MUL runs on an iterative shift-add unit when ALU_MUL_EN is defined;
// otherwise opcode 100 is reported as illegal.
// Ports:
//   Clock, Reset_n       clock, async active-low reset
//   OpValid/OpReady      op request handshake (OpReady high only in IDLE)
//   OpCode, OperandA/B   op to issue
//   AluA, AluB, Selector registered ALU inputs and result-mux select
//   MuxResult            combinational ALU mux output
//   ResValid/ResReady    result handshake
//   Result, IllegalOp    registered result and its illegal-op qualifier
//   Busy                 FSM not in IDLE
// -----------------------------------------------------------------------------
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 OpValid,
  output logic                 OpReady,
  input  logic [ALU_SEL_W-1:0] OpCode,
  input  logic [WIDTH-1:0]     OperandA,
  input  logic [WIDTH-1:0]     OperandB,
  output logic [WIDTH-1:0]     AluA,
  output logic [WIDTH-1:0]     AluB,
  output logic [ALU_SEL_W-1:0] Selector,
  input  logic [WIDTH-1:0]     MuxResult,
  output logic                 ResValid,
  input  logic                 ResReady,
  output logic [WIDTH-1:0]     Result,
  output logic                 IllegalOp,
  output logic                 Busy
);

  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_alu_a;
  logic [WIDTH-1:0]     r_alu_b;
  logic [ALU_SEL_W-1:0] r_sel;
  logic [WIDTH-1:0]     r_result;
  logic                 r_illegal;
  logic                 r_res_valid;
  logic                 w_accept;
  logic                 w_res_hs;

  assign w_accept = OpValid && (r_state == ST_IDLE);
  assign w_res_hs = r_res_valid && ResReady;

  assign OpReady   = (r_state == ST_IDLE);
  assign Busy      = (r_state != ST_IDLE);
  assign AluA      = r_alu_a;
  assign AluB      = r_alu_b;
  assign Selector  = r_sel;
  assign Result    = r_result;
  assign IllegalOp = r_illegal;
  assign ResValid  = r_res_valid;

`ifdef ALU_MUL_EN
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  // Operands are taken from the request port so the multiplier loads on the
  // same edge that AluA/AluB are captured.
  alu_op_sequencer_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .i_clk     (Clock),
    .i_rst_n   (Reset_n),
    .i_start   (w_accept && (OpCode == ALU_MUL)),
    .i_a       (OperandA),
    .i_b       (OperandB),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );
`endif

  // Sequencer FSM with operand, selector and result capture registers.
  // ResValid rises one cycle after entering DONE, which keeps Result settled
  // for a full cycle before it is offered downstream.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_alu_a     <= {WIDTH{1'b0}};
      r_alu_b     <= {WIDTH{1'b0}};
      r_sel       <= {ALU_SEL_W{1'b0}};
      r_result    <= {WIDTH{1'b0}};
      r_illegal   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_res_valid <= 1'b0;
          if (w_accept) begin
            r_alu_a <= OperandA;
            r_alu_b <= OperandB;
            r_sel   <= OpCode;
            if (is_single_cycle_op(OpCode)) begin
              r_state <= ST_EXEC;
`ifdef ALU_MUL_EN
            end else if (OpCode == ALU_MUL) begin
              r_state <= ST_MULT;
`endif
            end else begin
              r_state   <= ST_DONE;
              r_result  <= {WIDTH{1'b0}};
              r_illegal <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_result  <= MuxResult;
          r_illegal <= 1'b0;
          r_state   <= ST_DONE;
        end
`ifdef ALU_MUL_EN
        ST_MULT: begin
          if (w_mul_done) begin
            r_result  <= w_mul_product;
            r_illegal <= 1'b0;
            r_state   <= ST_DONE;
          end else begin
            r_state <= ST_MULT;
          end
        end
`endif
        ST_DONE: begin
          if (w_res_hs) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_res_valid <= 1'b1;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
